// File: rtl/timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : timer_ctrl
// Purpose  : Control stage for the DE1 countdown timer. It debounces the raw
//            start/load pushbuttons and runs the IDLE/RUN/PAUSE/DONE state
//            machine. It also drives the downstream BCD down-counter with a
//            per-second tick, a run enable and a preset load pulse.
// Ports    : CLOCK_50            - sole clock, rising edge
//            reset               - asynchronous, active-low reset
//            key_start, key_load - raw active-low pushbuttons (asynchronous)
//            sw_preset[7:0]      - BCD preset switches, tens in [7:4]
//            zero_in             - counter reports 00
//            run                 - counter enable level (state == RUN)
//            tick                - one-cycle decrement strobe, only in RUN
//            load                - one-cycle pulse; counter takes preset_bcd*
//            preset_bcd1/0       - latched, clamped preset digits
//            done                - high in DONE
//            state[1:0]          - IDLE=0, RUN=1, PAUSE=2, DONE=3
// Options  : define TIMER_CTRL_AUTORELOAD_EN to reload the latched preset on
//            zero instead of stopping in DONE. A preset of 00 still stops.
// Revision : 1.0 - initial release
// ============================================================================
module timer_ctrl #(
    parameter int DB_CYCLES = 1000000,
    parameter int TICK_DIV  = 50000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_start,
    input  logic       key_load,
    input  logic [7:0] sw_preset,
    input  logic       zero_in,
    output logic       run,
    output logic       tick,
    output logic       load,
    output logic [3:0] preset_bcd1,
    output logic [3:0] preset_bcd0,
    output logic       done,
    output logic [1:0] state
);

    localparam int c_DB_W = $clog2(DB_CYCLES + 1);
    localparam int c_PS_W = $clog2(TICK_DIV);

    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE  = c_DB_W'(1);
    localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(TICK_DIV - 1);
    localparam logic [c_PS_W-1:0] c_PS_ONE  = c_PS_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Key input path: 2-FF synchronizer, then a debounce counter that
    // accepts a new level only after DB_CYCLES consecutive disagreeing
    // samples. A press strobe is registered on the accepted 1->0 change.
    // Bit 0 = start key, bit 1 = load key.
    // ------------------------------------------------------------------
    logic [1:0] w_key_raw;
    logic [1:0] w_press;

    assign w_key_raw = {key_load, key_start};

    for (genvar gi = 0; gi < 2; gi++) begin : g_key
        logic              r_sync1;
        logic              r_sync2;
        logic              r_level;
        logic              r_press;
        logic [c_DB_W-1:0] r_cnt;

        always_ff @(posedge CLOCK_50 or negedge reset) begin
            if (!reset) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
                r_level <= 1'b1;
                r_press <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_key_raw[gi];
                r_sync2 <= r_sync1;
                r_press <= 1'b0;
                if (r_sync2 == r_level) begin
                    // Any agreeing sample restarts the stability count.
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2;
                    r_press <= ~r_sync2;
                end else begin
                    r_cnt <= r_cnt + c_DB_ONE;
                end
            end
        end

        assign w_press[gi] = r_press;
    end

    // A start coinciding with a load is treated as a load only.
    logic w_load_evt;
    logic w_start_evt;

    assign w_load_evt  = w_press[1];
    assign w_start_evt = w_press[0] & ~w_press[1];

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_next;
    logic   w_load_now;   // issue a load pulse on this edge
    logic   w_take_sw;    // latch the switch preset on this edge

    logic              r_run;
    logic              r_done;
    logic              r_tick;
    logic              r_load;
    logic [c_PS_W-1:0] r_ps;
    logic [7:0]        r_preset;

    always_comb begin
        w_next     = r_state;
        w_load_now = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_load_evt) begin
                    w_load_now = 1'b1;
                end else if (w_start_evt) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                // Zero wins over any key event; load keys are ignored here.
                if (zero_in) begin
`ifdef TIMER_CTRL_AUTORELOAD_EN
                    // Reloading a 00 preset would loop forever, so stop.
                    if (r_preset == 8'h00) begin
                        w_next = S_DONE;
                    end else begin
                        w_load_now = 1'b1;
                    end
`else
                    w_next = S_DONE;
`endif
                end else if (w_start_evt) begin
                    w_next = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (w_load_evt) begin
                    w_load_now = 1'b1;
                    w_next     = S_IDLE;
                end else if (w_start_evt) begin
                    w_next = S_RUN;
                end
            end
            S_DONE: begin
                if (w_load_evt) begin
                    w_load_now = 1'b1;
                    w_next     = S_IDLE;
                end else if (w_start_evt) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Only key-driven loads take new switches; an autoreload in RUN reuses
    // the preset that is already latched.
    assign w_take_sw = w_load_now & (r_state != S_RUN);

    // ------------------------------------------------------------------
    // Prescaler: cleared on IDLE->RUN and advanced only while in RUN.
    // Resuming from PAUSE continues from the held count. If RUN is left
    // exactly on the terminal count, that count is held so the pending
    // tick is issued right after a resume instead of being lost.
    // ------------------------------------------------------------------
    logic [c_PS_W-1:0] w_ps_next;
    logic              w_tick_now;

    always_comb begin
        w_ps_next  = r_ps;
        w_tick_now = 1'b0;
        if (r_state == S_IDLE && w_next == S_RUN) begin
            w_ps_next = '0;
        end else if (r_state == S_RUN) begin
            if (r_ps == c_PS_LAST) begin
                if (w_next == S_RUN) begin
                    w_ps_next  = '0;
                    w_tick_now = 1'b1;
                end
            end else begin
                w_ps_next = r_ps + c_PS_ONE;
            end
        end
    end

    function automatic logic [3:0] f_clamp_bcd(input logic [3:0] nib);
        return (nib > 4'd9) ? 4'd9 : nib;
    endfunction

    // ------------------------------------------------------------------
    // Registers. run/done decode the next state so that they move on the
    // same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_run    <= 1'b0;
            r_done   <= 1'b0;
            r_tick   <= 1'b0;
            r_load   <= 1'b0;
            r_ps     <= '0;
            r_preset <= 8'h00;
        end else begin
            r_state <= w_next;
            r_run   <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
            r_tick  <= w_tick_now;
            r_load  <= w_load_now;
            r_ps    <= w_ps_next;
            if (w_take_sw) begin
                r_preset <= {f_clamp_bcd(sw_preset[7:4]), f_clamp_bcd(sw_preset[3:0])};
            end
        end
    end

    assign run         = r_run;
    assign done        = r_done;
    assign tick        = r_tick;
    assign load        = r_load;
    assign preset_bcd1 = r_preset[7:4];
    assign preset_bcd0 = r_preset[3:0];
    assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_ctrl
// Purpose  : Self-checking bench for timer_ctrl. A cycle-level behavioural
//            model of the key path and the controller is stepped alongside
//            the DUT. Every output is compared on each falling edge. Directed
//            scenarios are followed by a randomized key/zero/switch phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_ctrl;

    localparam int DB = 4;
    localparam int TD = 10;

    logic       CLOCK_50  = 1'b0;
    logic       reset     = 1'b0;
    logic       key_start = 1'b1;
    logic       key_load  = 1'b1;
    logic [7:0] sw_preset = 8'h00;
    logic       zero_in   = 1'b0;
    logic       run;
    logic       tick;
    logic       load;
    logic [3:0] preset_bcd1;
    logic [3:0] preset_bcd0;
    logic       done;
    logic [1:0] state;

    timer_ctrl #(
        .DB_CYCLES(DB),
        .TICK_DIV (TD)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .key_start  (key_start),
        .key_load   (key_load),
        .sw_preset  (sw_preset),
        .zero_in    (zero_in),
        .run        (run),
        .tick       (tick),
        .load       (load),
        .preset_bcd1(preset_bcd1),
        .preset_bcd0(preset_bcd0),
        .done       (done),
        .state      (state)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_st;              // 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
    int m_ps;              // RUN cycles accumulated toward the next tick
    bit m_tick, m_load;
    int m_p1, m_p0;
    bit m_lvl[2];          // accepted key level per key
    int m_diff[2];         // consecutive synced samples disagreeing with it
    bit m_evt[2];          // press strobe raised on this edge
    bit hist_s[$];         // raw key_start per edge since reset
    bit hist_l[$];         // raw key_load per edge since reset

    function automatic int clamp9(input int v);
        return (v > 9) ? 9 : v;
    endfunction

    // The debouncer sees the raw value from two edges earlier, or the
    // released level for the first two edges after reset.
    function automatic bit synced_of(input int k);
        int n;
        n = (k == 0) ? hist_s.size() : hist_l.size();
        if (n < 3) return 1'b1;
        return (k == 0) ? hist_s[n-3] : hist_l[n-3];
    endfunction

    task automatic model_reset();
        m_st = 0; m_ps = 0; m_tick = 0; m_load = 0; m_p1 = 0; m_p0 = 0;
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = 1'b1; m_diff[k] = 0; m_evt[k] = 1'b0;
        end
        hist_s.delete();
        hist_l.delete();
    endtask

    task automatic model_step();
        bit ev_s, ev_l, ld, take, sv;
        int nxt;
        ev_l = m_evt[1];
        ev_s = m_evt[0] && !m_evt[1];
        nxt = m_st; ld = 0; take = 0;
        case (m_st)
            0: if (ev_l) begin ld = 1; take = 1; end
               else if (ev_s) nxt = 1;
            1: if (zero_in) begin
`ifdef TIMER_CTRL_AUTORELOAD_EN
                   if (m_p1 == 0 && m_p0 == 0) nxt = 3; else ld = 1;
`else
                   nxt = 3;
`endif
               end else if (ev_s) nxt = 2;
            2: if (ev_l) begin ld = 1; take = 1; nxt = 0; end
               else if (ev_s) nxt = 1;
            default: if (ev_l) begin ld = 1; take = 1; nxt = 0; end
               else if (ev_s) nxt = 0;
        endcase
        m_tick = 0;
        if (m_st == 0 && nxt == 1) m_ps = 0;
        else if (m_st == 1) begin
            if (m_ps == TD - 1) begin
                if (nxt == 1) begin m_tick = 1; m_ps = 0; end
            end else m_ps++;
        end
        if (take) begin
            m_p1 = clamp9(int'(sw_preset[7:4]));
            m_p0 = clamp9(int'(sw_preset[3:0]));
        end
        m_load = ld;
        m_st = nxt;
        hist_s.push_back(key_start);
        hist_l.push_back(key_load);
        for (int k = 0; k < 2; k++) begin
            m_evt[k] = 1'b0;
            sv = synced_of(k);
            if (sv != m_lvl[k]) begin
                m_diff[k]++;
                if (m_diff[k] == DB) begin
                    m_lvl[k] = sv; m_diff[k] = 0; m_evt[k] = !sv;
                end
            end else m_diff[k] = 0;
        end
    endtask

    // ------------------------------------------------------------------
    // Cycle driver and monitors
    // ------------------------------------------------------------------
    int n_cyc = 0, n_load = 0, n_tick = 0, run_rise = 0, last_tick = 0;
    bit prev_run = 0;

    task automatic compare_all();
        check("state",   32'(state),       32'(m_st));
        check("run",     32'(run),         32'(m_st == 1));
        check("done",    32'(done),        32'(m_st == 3));
        check("tick",    32'(tick),        32'(m_tick));
        check("load",    32'(load),        32'(m_load));
        check("preset1", 32'(preset_bcd1), 32'(m_p1));
        check("preset0", 32'(preset_bcd0), 32'(m_p0));
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        if (reset) model_step(); else model_reset();
        @(negedge CLOCK_50);
        n_cyc++;
        compare_all();
        if (load) n_load++;
        if (tick) begin n_tick++; last_tick = n_cyc; end
        if (run && !prev_run) run_rise = n_cyc;
        prev_run = run;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic press(input bit s, input bit l, input int hold);
        if (s) key_start = 1'b0;
        if (l) key_load  = 1'b0;
        repeat (hold) cyc();
        key_start = 1'b1;
        key_load  = 1'b1;
    endtask

    task automatic wait_tick(input int limit);
        int i;
        i = 0;
        do begin
            cyc();
            i++;
        end while (!tick && i < limit);
        if (!tick) check("tick_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int l0, nt, t0;
        int hold_s, hold_l;

        // Reset state
        model_reset();
        idle(3);
        check("rst_state", 32'(state), 32'(0));
        check("rst_run",   32'(run),   32'(0));
        reset = 1'b1;
        idle(4);

        // Glitch shorter than the debounce window
        press(1, 0, 3);
        idle(10);
        check("glitch_state", 32'(state), 32'(0));

        // Load with clamping of an out-of-range tens digit
        sw_preset = 8'hA7;
        l0 = n_load;
        press(0, 1, 6);
        idle(8);
        check("clamp_hi",    32'(preset_bcd1), 32'(9));
        check("clamp_lo",    32'(preset_bcd0), 32'(7));
        check("clamp_loads", 32'(n_load - l0), 32'(1));
        check("clamp_state", 32'(state),       32'(0));

        // Clean 8-cycle press: RUN exactly 2+DB+1 edges after the drop
        key_start = 1'b0;
        idle(6);
        check("db_pre_state", 32'(state), 32'(0));
        cyc();
        check("db_state", 32'(state), 32'(1));
        check("db_run",   32'(run),   32'(1));
        cyc();
        key_start = 1'b1;
        wait_tick(30);
        check("first_tick", 32'(last_tick - run_rise), 32'(TD));
        t0 = last_tick;
        wait_tick(30);
        check("tick_period", 32'(last_tick - t0), 32'(TD));

        // Pause three RUN cycles after a tick, then resume
        idle(6);
        press(1, 0, 6);
        idle(8);
        check("pause_state", 32'(state), 32'(2));
        nt = n_tick;
        idle(20);
        check("pause_ticks", 32'(n_tick - nt), 32'(0));
        press(1, 0, 6);
        wait_tick(30);
        check("resume_gap", 32'(last_tick - run_rise), 32'(7));
        idle(8);

`ifdef TIMER_CTRL_AUTORELOAD_EN
        // Autoreload: nonzero preset reloads and keeps running
        press(1, 0, 6); idle(8);               // -> PAUSE
        sw_preset = 8'h03;
        press(0, 1, 6); idle(8);               // -> IDLE, preset 03
        press(1, 0, 6); idle(8);               // -> RUN
        zero_in = 1'b1;
        cyc();
        zero_in = 1'b0;
        check("auto_load",  32'(load),  32'(1));
        check("auto_state", 32'(state), 32'(1));
        check("auto_done",  32'(done),  32'(0));
        idle(4);
        press(1, 0, 6); idle(8);               // -> PAUSE
        sw_preset = 8'h00;
        press(0, 1, 6); idle(8);               // -> IDLE, preset 00
        press(1, 0, 6); idle(8);               // -> RUN
        zero_in = 1'b1;
        cyc();
        zero_in = 1'b0;
        check("auto_zero_state", 32'(state), 32'(3));
        press(1, 0, 6); idle(8);               // -> IDLE
`else
        // Zero in RUN: DONE on the next edge, no further ticks
        zero_in = 1'b1;
        cyc();
        zero_in = 1'b0;
        check("zero_state", 32'(state), 32'(3));
        check("zero_done",  32'(done),  32'(1));
        check("zero_run",   32'(run),   32'(0));
        nt = n_tick;
        idle(15);
        check("done_ticks", 32'(n_tick - nt), 32'(0));
        press(1, 0, 6);
        idle(2);
        check("done_exit_state", 32'(state), 32'(0));
        check("done_exit_done",  32'(done),  32'(0));
        idle(6);
`endif

        // Simultaneous start+load in PAUSE resolves as a single load
        press(1, 0, 6); idle(8);
        press(1, 0, 6); idle(8);
        check("pre_sim_state", 32'(state), 32'(2));
        l0 = n_load;
        press(1, 1, 6);
        idle(8);
        check("sim_loads", 32'(n_load - l0), 32'(1));
        check("sim_state", 32'(state),       32'(0));

        // Asynchronous reset in the middle of a debounce while running
        press(1, 0, 6); idle(8);
        check("pre_rst_run", 32'(run), 32'(1));
        key_start = 1'b0;
        idle(3);
        reset = 1'b0;
        #1;
        check("arst_run",   32'(run),         32'(0));
        check("arst_state", 32'(state),       32'(0));
        check("arst_tick",  32'(tick),        32'(0));
        check("arst_load",  32'(load),        32'(0));
        check("arst_done",  32'(done),        32'(0));
        check("arst_pre1",  32'(preset_bcd1), 32'(0));
        idle(2);
        reset = 1'b1;
        key_start = 1'b1;
        idle(15);
        check("post_rst_state", 32'(state), 32'(0));
        check("post_rst_run",   32'(run),   32'(0));

        // Randomized keys, zero reports, switches and occasional resets
        hold_s = 0;
        hold_l = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold_s == 0) begin
                key_start = 1'($urandom_range(0, 1));
                hold_s = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(5, 16));
            end
            if (hold_l == 0) begin
                key_load = 1'($urandom_range(0, 1));
                hold_l = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                     : int'($urandom_range(5, 24));
            end
            hold_s--;
            hold_l--;
            zero_in   = ($urandom_range(0, 19) == 0);
            sw_preset = 8'($urandom);
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 499) == 0) reset = 1'b0;
            cyc();
        end
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
